// File: rtl/axi_10g_ethernet_0_pkg.sv
// rtl/axi_10g_ethernet_0_pkg.sv - ARP header constants, event type and header byte map
package axi_10g_ethernet_0_pkg;

   localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
   localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  ARP_HLEN       = 8'd6;
   localparam logic [7:0]  ARP_PLEN       = 8'd4;
   localparam logic [15:0] ARP_OP_REQ     = 16'd1;
   localparam logic [15:0] ARP_OP_REP     = 16'd2;
   localparam logic [6:0]  ARP_MIN_BYTES  = 7'd42;
   localparam int          FLD_BYTES      = 30;

   typedef struct packed {
      logic        op;
      logic [47:0] mac;
      logic [31:0] ip;
   } arp_event_t;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_TAIL} parse_state_t;

   // Maps a frame byte offset to {hit, slot}; only the bytes the checker inspects get a slot.
   function automatic logic [5:0] fld_slot(input logic [7:0] off);
      if (off < 8'd6)                    return {1'b1, off[4:0]};
      if (off >= 8'd12 && off < 8'd32)   return {1'b1, off[4:0] - 5'd6};
      if (off >= 8'd38 && off < 8'd42)   return {1'b1, off[4:0] - 5'd12};
      return 6'd0;
   endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_sync_fifo.sv
// rtl/axi_10g_ethernet_0_sync_fifo.sv - first-word-fall-through event FIFO, pop frees a slot for a same-cycle push
module axi_10g_ethernet_0_sync_fifo #(
   parameter int WIDTH = 81,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_10g_ethernet_0_arp_rx_engine.sv
// rtl/axi_10g_ethernet_0_arp_rx_engine.sv - width-parametrised ARP RX parser with event FIFO
// Optional statistics counters are built when ARP_RX_STATS_EN is defined.
module axi_10g_ethernet_0_arp_rx_engine
   import axi_10g_ethernet_0_pkg::*;
#(
   parameter int          DATA_WIDTH = 64,
   parameter logic [47:0] BOARD_MAC  = 48'h02_00_c0_a8_0a_0a,
   parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd2, 8'd20},
   parameter int          FIFO_DEPTH = 4,
   localparam int         KEEP_W     = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
   input  logic [KEEP_W-1:0]     rx_axis_tkeep,
   input  logic                  rx_axis_tvalid,
   input  logic                  rx_axis_tlast,
   output logic                  rx_axis_tready,
   output logic                  arp_valid,
   input  logic                  arp_ready,
   output logic                  arp_op,
   output logic [47:0]           arp_src_mac,
   output logic [31:0]           arp_src_ip,
`ifdef ARP_RX_STATS_EN
   output logic [31:0]           stat_req_cnt,
   output logic [31:0]           stat_rep_cnt,
   output logic [31:0]           stat_drop_cnt,
`endif
   output logic                  rx_drop_pulse
);

   parse_state_t state;
   logic [6:0]   byte_cnt;
   logic [6:0]   cnt_nxt;
   logic [7:0]   base;
   logic [7:0]   sum;
   logic [5:0]   lanes;
   logic [5:0]   slot;
   logic         beat;
   logic [7:0]   fld      [FLD_BYTES];
   logic [7:0]   fld_nxt  [FLD_BYTES];
   logic [7:0]   pend_fld [FLD_BYTES];
   logic [6:0]   pend_cnt;
   logic         pend_v;

   assign rx_axis_tready = 1'b1;
   assign beat           = rx_axis_tvalid & (|rx_axis_tkeep);

   always_comb begin
      fld_nxt = fld;
      lanes   = '0;
      slot    = '0;
      base    = (state == ST_IDLE) ? 8'd0 : {1'b0, byte_cnt};
      for (int k = 0; k < KEEP_W; k++) begin
         if (rx_axis_tvalid && rx_axis_tkeep[k]) begin
            lanes = lanes + 6'd1;
            slot  = fld_slot(base + 8'(k));
            if (slot[5]) fld_nxt[slot[4:0]] = rx_axis_tdata[8*k +: 8];
         end
      end
      sum     = base + {2'b00, lanes};
      cnt_nxt = (sum > 8'd127) ? 7'd127 : sum[6:0];
   end

   // The tlast beat's bytes go straight into the pending copy so the parser can start the next frame at once.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state    <= ST_IDLE;
         byte_cnt <= '0;
         pend_v   <= 1'b0;
      end else begin
         fld    <= fld_nxt;
         pend_v <= 1'b0;
         if (beat) begin
            if (rx_axis_tlast) begin
               state    <= ST_IDLE;
               byte_cnt <= '0;
               pend_v   <= 1'b1;
               pend_cnt <= cnt_nxt;
               pend_fld <= fld_nxt;
            end else begin
               state    <= (cnt_nxt >= ARP_MIN_BYTES) ? ST_TAIL : ST_HDR;
               byte_cnt <= cnt_nxt;
            end
         end
      end
   end

   logic [47:0] p_da;
   logic [15:0] p_oper;
   logic        hdr_ok;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_ok;
   logic        push;
   arp_event_t  ev_in;
   arp_event_t  ev_out;

   assign p_da   = {pend_fld[0], pend_fld[1], pend_fld[2], pend_fld[3], pend_fld[4], pend_fld[5]};
   assign p_oper = {pend_fld[14], pend_fld[15]};

   assign hdr_ok = (pend_cnt >= ARP_MIN_BYTES)
                && (p_da == BOARD_MAC || p_da == 48'hffff_ffff_ffff)
                && ({pend_fld[6],  pend_fld[7]}  == ETH_TYPE_ARP)
                && ({pend_fld[8],  pend_fld[9]}  == ARP_HTYPE_ETH)
                && ({pend_fld[10], pend_fld[11]} == ARP_PTYPE_IPV4)
                && (pend_fld[12] == ARP_HLEN)
                && (pend_fld[13] == ARP_PLEN)
                && (p_oper == ARP_OP_REQ || p_oper == ARP_OP_REP)
                && ({pend_fld[26], pend_fld[27], pend_fld[28], pend_fld[29]} == BOARD_IP);

   assign ev_in.op  = (p_oper == ARP_OP_REP);
   assign ev_in.mac = {pend_fld[16], pend_fld[17], pend_fld[18], pend_fld[19], pend_fld[20], pend_fld[21]};
   assign ev_in.ip  = {pend_fld[22], pend_fld[23], pend_fld[24], pend_fld[25]};

   // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
   assign fifo_ok       = ~fifo_full | (arp_valid & arp_ready);
   assign push          = pend_v & hdr_ok & fifo_ok & ~areset;
   assign rx_drop_pulse = pend_v & ~(hdr_ok & fifo_ok) & ~areset;

   axi_10g_ethernet_0_sync_fifo #(
      .WIDTH ($bits(arp_event_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_evq (
      .clk   (aclk),
      .rst   (areset),
      .push  (push),
      .din   (ev_in),
      .pop   (arp_ready),
      .dout  (ev_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign arp_valid   = ~fifo_empty;
   assign arp_op      = ev_out.op;
   assign arp_src_mac = ev_out.mac;
   assign arp_src_ip  = ev_out.ip;

`ifdef ARP_RX_STATS_EN
   always_ff @(posedge aclk) begin
      if (areset) begin
         stat_req_cnt  <= '0;
         stat_rep_cnt  <= '0;
         stat_drop_cnt <= '0;
      end else begin
         if (push && !ev_in.op) stat_req_cnt  <= stat_req_cnt + 32'd1;
         if (push &&  ev_in.op) stat_rep_cnt  <= stat_rep_cnt + 32'd1;
         if (rx_drop_pulse)     stat_drop_cnt <= stat_drop_cnt + 32'd1;
      end
   end
`endif

endmodule
